// File: rtl/pwm_capture.sv
// PWM input decoder: measures high time and period of pwm_i in clk_i cycles
// and exposes them, with control/status, through a valid/ready register port.
module pwm_capture #(
  parameter int BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  output logic        irq_o
);

  // Register port: a request is accepted when valid_i is high and no ack is
  // outstanding; ready_o/rdata_o are registered and high for one cycle, and
  // writes and read side effects take place at the accepting edge.

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_HIGH    = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;

  localparam logic [BITS-1:0] CNT_MAX = '1;
  localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMING  = 2'd1,
    S_MEASURE = 2'd2
  } state_e;

  // Bus side
  logic            ready_q;
  logic [31:0]     rdata_q;
  logic [31:0]     rdata_d;
  logic [2:0]      ctrl_q;
  logic [BITS-1:0] timeout_q;

  // Input path
  logic sync1_q;
  logic sync2_q;
  logic lvl_q;
  logic lvl;
  logic rise;
  logic fall;

  // Measurement
  state_e          state_q;
  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] high_lat_q;
  logic [BITS-1:0] high_q;
  logic [BITS-1:0] period_q;
  logic            valid_q;
  logic            ovf_q;
  logic            stall_q;
  logic            void_q;

  logic       acc;
  logic       wr;
  logic       rd;
  logic [2:0] sel;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_timeout;
  logic       rd_period;
  logic       en_eff;
  logic       unused_bits;

  assign sel        = addr_i[4:2];
  assign acc        = valid_i & ~ready_q;
  assign wr         = acc & we_i;
  assign rd         = acc & ~we_i;
  assign wr_ctrl    = wr && (sel == ADDR_CTRL);
  assign wr_status  = wr && (sel == ADDR_STATUS);
  assign wr_timeout = wr && (sel == ADDR_TIMEOUT);
  assign rd_period  = rd && (sel == ADDR_PERIOD);

  // A CTRL write disabling the block must win over an edge in the same cycle.
  assign en_eff = wr_ctrl ? wdata_i[0] : ctrl_q[0];

  assign lvl  = sync2_q ^ ctrl_q[1];
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  assign unused_bits = &{1'b0, addr_i[31:5], addr_i[1:0], wdata_i};

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (sel)
        ADDR_CTRL:    rdata_d[2:0]      = ctrl_q;
        ADDR_STATUS:  rdata_d[3:0]      = {lvl, stall_q, ovf_q, valid_q};
        ADDR_HIGH:    rdata_d[BITS-1:0] = high_q;
        ADDR_PERIOD:  rdata_d[BITS-1:0] = period_q;
        ADDR_TIMEOUT: rdata_d[BITS-1:0] = timeout_q;
        default:      rdata_d           = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      timeout_q <= '0;
    end else begin
      ready_q <= acc;
      rdata_q <= rdata_d;
      if (wr_ctrl)    ctrl_q    <= wdata_i[2:0];
      if (wr_timeout) timeout_q <= wdata_i[BITS-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl;
    end
  end

  // Later assignments override earlier ones, so hardware sets of valid and
  // ovf take priority over the bus-side clears placed first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      stall_q    <= 1'b0;
      void_q     <= 1'b0;
    end else begin
      if (rd_period)               valid_q <= 1'b0;
      if (wr_status && wdata_i[1]) ovf_q   <= 1'b0;
      if (!en_eff) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        high_lat_q <= '0;
        stall_q    <= 1'b0;
        void_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q    <= S_ARMING;
            cnt_q      <= '0;
            high_lat_q <= '0;
            stall_q    <= 1'b0;
            void_q     <= 1'b0;
          end
          S_ARMING: begin
            if (rise) begin
              cnt_q   <= CNT_ONE;
              state_q <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if ((timeout_q != '0) && (cnt_q == timeout_q)) stall_q <= 1'b1;
            if (fall) high_lat_q <= cnt_q;
            if (rise) begin
              if (!void_q) begin
                high_q   <= high_lat_q;
                period_q <= cnt_q;
                valid_q  <= 1'b1;
                stall_q  <= 1'b0;
              end
              cnt_q  <= CNT_ONE;
              void_q <= 1'b0;
            end else if (cnt_q == CNT_MAX) begin
              ovf_q  <= 1'b1;
              void_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign irq_o   = valid_q & ctrl_q[2];

endmodule
